// File: rtl/aq_lsu_nwa_wmb_pkg.sv
// Shared types and line geometry for the no-write-allocate store merge buffer.
// Holds FSM encodings, the BIU beat layout and the byte-enable placement helper.
package aq_lsu_nwa_wmb_pkg;

    localparam int LINE_BYTES  = 64;
    localparam int DW_PER_LINE = 8;
    localparam int OFFSET_W    = 6;
    localparam int NWA_PADDR   = 40;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MERGE     = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_WAIT_RESP = 2'd3
    } nwa_state_e;

    typedef struct packed {
        logic [NWA_PADDR-1:0] addr;
        logic [63:0]          data;
        logic [7:0]           be;
        logic                 burst;
        logic                 last;
    } nwa_beat_t;

    function automatic logic [LINE_BYTES-1:0] place_be(input logic [7:0] be, input logic [2:0] dw);
        place_be = {{(LINE_BYTES-8){1'b0}}, be} << {dw, 3'b000};
    endfunction

endpackage

// File: rtl/aq_lsu_nwa_wmb_if.sv
// DC store / CP0 sync / BIU write signals of the merge buffer.
// slave = the buffer itself, master = its surroundings (dc, cp0, biu).
interface aq_lsu_nwa_wmb_if #(parameter int PADDR = 40);
    logic             amr_dc_wa_dis;
    logic             dc_nwa_st_req;
    logic [PADDR-1:0] dc_nwa_st_addr;
    logic [63:0]      dc_nwa_st_data;
    logic [7:0]       dc_nwa_st_be;
    logic             nwa_dc_st_grnt;
    logic             cp0_lsu_sync_req;
    logic             nwa_empty;
    logic             nwa_biu_req;
    logic [PADDR-1:0] nwa_biu_addr;
    logic [63:0]      nwa_biu_data;
    logic [7:0]       nwa_biu_be;
    logic             nwa_biu_burst;
    logic             nwa_biu_last;
    logic             biu_nwa_grnt;
    logic             biu_nwa_resp;

    modport slave (
        input  amr_dc_wa_dis, dc_nwa_st_req, dc_nwa_st_addr, dc_nwa_st_data, dc_nwa_st_be,
        input  cp0_lsu_sync_req, biu_nwa_grnt, biu_nwa_resp,
        output nwa_dc_st_grnt, nwa_empty, nwa_biu_req, nwa_biu_addr, nwa_biu_data,
        output nwa_biu_be, nwa_biu_burst, nwa_biu_last
    );

    modport master (
        output amr_dc_wa_dis, dc_nwa_st_req, dc_nwa_st_addr, dc_nwa_st_data, dc_nwa_st_be,
        output cp0_lsu_sync_req, biu_nwa_grnt, biu_nwa_resp,
        input  nwa_dc_st_grnt, nwa_empty, nwa_biu_req, nwa_biu_addr, nwa_biu_data,
        input  nwa_biu_be, nwa_biu_burst, nwa_biu_last
    );
endinterface

// File: rtl/aq_lsu_nwa_wmb_pick.sv
// Picks the lowest dword at or above i_idx that has any valid byte; o_none when none remain.
// Purely combinational.
module aq_lsu_nwa_pick
    import aq_lsu_nwa_wmb_pkg::*;
(
    input  logic [LINE_BYTES-1:0] i_mask,
    input  logic [2:0]            i_idx,
    output logic [2:0]            o_idx,
    output logic                  o_none
);
    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        // Descending scan so the lowest qualifying dword is the one left standing.
        for (int i = DW_PER_LINE - 1; i >= 0; i--) begin
            if ((3'(i) >= i_idx) && (|i_mask[i*8 +: 8])) begin
                o_idx  = 3'(i);
                o_none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/aq_lsu_nwa_wmb.sv
// No-write-allocate store merge buffer: one 64B entry drained as an 8-beat burst or per-dword writes.
// Grant is same-cycle; beats hold until biu_nwa_grnt. Optional idle drain: AQ_LSU_NWA_TIMEOUT_EN.
module aq_lsu_nwa_wmb
    import aq_lsu_nwa_wmb_pkg::*;
#(
    parameter int PADDR = 40,
    parameter int TMO_W = 4
) (
    input  logic             amr_clk,
    input  logic             cpurst_b,
    aq_lsu_nwa_wmb_if.slave  io
);
    localparam int TAG_W = PADDR - OFFSET_W;

    nwa_state_e            r_state, w_state_nxt;
    logic                  r_valid;
    logic [TAG_W-1:0]      r_tag;
    logic [LINE_BYTES-1:0] r_mask;
    logic [63:0]           r_data [DW_PER_LINE];
    logic [2:0]            r_idx;
    logic                  r_burst;

    logic [TAG_W-1:0]      w_st_tag;
    logic [2:0]            w_st_dw;
    logic                  w_tag_hit, w_grnt, w_trig, w_tmo_hit, w_req;
    logic [LINE_BYTES-1:0] w_be_line, w_mask_upd;
    logic [2:0]            w_pick_idx, w_beat_idx;
    logic                  w_pick_none;
    nwa_beat_t             w_beat;
    logic                  w_unused;

    assign w_st_tag   = io.dc_nwa_st_addr[PADDR-1:OFFSET_W];
    assign w_st_dw    = io.dc_nwa_st_addr[OFFSET_W-1:3];
    assign w_unused   = &{1'b0, io.dc_nwa_st_addr[2:0]};
    assign w_tag_hit  = r_valid && (w_st_tag == r_tag);
    assign w_grnt     = io.dc_nwa_st_req && io.amr_dc_wa_dis &&
                        ((r_state == ST_IDLE) || ((r_state == ST_MERGE) && w_tag_hit));
    assign w_be_line  = place_be(io.dc_nwa_st_be, w_st_dw);
    assign w_mask_upd = r_mask | (w_grnt ? w_be_line : '0);
    // A granted store is folded into the mask before the drain decision is made.
    assign w_trig     = (&w_mask_upd) || (io.dc_nwa_st_req && !w_tag_hit) ||
                        !io.amr_dc_wa_dis || io.cp0_lsu_sync_req || w_tmo_hit;

`ifdef AQ_LSU_NWA_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo;
    always_ff @(posedge amr_clk or negedge cpurst_b) begin
        if (!cpurst_b)                           r_tmo <= '0;
        else if (r_state != ST_MERGE || w_grnt)  r_tmo <= '0;
        else                                     r_tmo <= r_tmo + 1'b1;
    end
    assign w_tmo_hit = (r_state == ST_MERGE) && (&r_tmo);
`else
    assign w_tmo_hit = (TMO_W < 1);
`endif

    aq_lsu_nwa_pick u_pick (
        .i_mask (r_mask),
        .i_idx  (r_idx),
        .o_idx  (w_pick_idx),
        .o_none (w_pick_none)
    );

    assign w_beat_idx = r_burst ? r_idx : w_pick_idx;
    assign w_req      = (r_state == ST_DRAIN) && (r_burst || !w_pick_none);

    always_comb begin
        w_beat = '0;
        if (w_req) begin
            w_beat.addr  = NWA_PADDR'({r_tag, w_beat_idx, 3'b000});
            w_beat.data  = r_data[w_beat_idx];
            w_beat.be    = r_burst ? 8'hFF : r_mask[{w_beat_idx, 3'b000} +: 8];
            w_beat.burst = r_burst;
            w_beat.last  = !r_burst || (r_idx == 3'd7);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_grnt) w_state_nxt = ST_MERGE;
            ST_MERGE: if (w_trig) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (r_burst) begin
                    if (io.biu_nwa_grnt && r_idx == 3'd7) w_state_nxt = ST_WAIT_RESP;
                end else if (w_pick_none) begin
                    w_state_nxt = ST_IDLE;
                end else if (io.biu_nwa_grnt) begin
                    w_state_nxt = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (io.biu_nwa_resp)
                    w_state_nxt = (r_burst || w_pick_none) ? ST_IDLE : ST_DRAIN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge amr_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_mask  <= '0;
            r_idx   <= '0;
            r_burst <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: if (w_grnt) begin
                    r_valid <= 1'b1;
                    r_tag   <= w_st_tag;
                    r_mask  <= w_be_line;
                    r_idx   <= '0;
                end
                ST_MERGE: begin
                    r_mask <= w_mask_upd;
                    if (w_state_nxt == ST_DRAIN) begin
                        r_burst <= &w_mask_upd;
                        r_idx   <= '0;
                    end
                end
                ST_DRAIN: if (w_req && io.biu_nwa_grnt) begin
                    if (r_burst) begin
                        r_idx <= r_idx + 3'd1;
                    end else begin
                        // Retire the sent dword so the picker skips it on the next pass.
                        r_idx <= w_pick_idx + 3'd1;
                        r_mask[{w_pick_idx, 3'b000} +: 8] <= '0;
                    end
                end
                default: ;
            endcase
            if (r_state != ST_IDLE && w_state_nxt == ST_IDLE) begin
                r_valid <= 1'b0;
                r_mask  <= '0;
                r_idx   <= '0;
                r_burst <= 1'b0;
            end
        end
    end

    always_ff @(posedge amr_clk) begin
        if (w_grnt) begin
            for (int b = 0; b < 8; b++) begin
                if (io.dc_nwa_st_be[b]) r_data[w_st_dw][b*8 +: 8] <= io.dc_nwa_st_data[b*8 +: 8];
            end
        end
    end

    assign io.nwa_dc_st_grnt = w_grnt;
    assign io.nwa_empty      = (r_state == ST_IDLE) && !r_valid;
    assign io.nwa_biu_req    = w_req;
    assign io.nwa_biu_addr   = w_beat.addr[PADDR-1:0];
    assign io.nwa_biu_data   = w_beat.data;
    assign io.nwa_biu_be     = w_beat.be;
    assign io.nwa_biu_burst  = w_beat.burst;
    assign io.nwa_biu_last   = w_beat.last;
endmodule

// File: tb/tb_aq_lsu_nwa_wmb.sv
// Directed bench for the merge buffer: full-line burst, partial drain, merge, tag miss,
// backpressure, wa_dis fall, idle sync and the absence of an idle drain in the default build.
module tb_aq_lsu_nwa_wmb;
    localparam int PADDR = 40;

    logic amr_clk  = 1'b0;
    logic cpurst_b = 1'b0;
    int   n_test   = 0;
    int   n_fail   = 0;

    aq_lsu_nwa_wmb_if #(.PADDR(PADDR)) io ();

    aq_lsu_nwa_wmb #(.PADDR(PADDR), .TMO_W(4)) dut (
        .amr_clk  (amr_clk),
        .cpurst_b (cpurst_b),
        .io       (io)
    );

    always #5 amr_clk = ~amr_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_test++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [PADDR-1:0] a, input logic [63:0] d, input logic [7:0] be,
                         input logic sync);
        io.dc_nwa_st_req    = 1'b1;
        io.dc_nwa_st_addr   = a;
        io.dc_nwa_st_data   = d;
        io.dc_nwa_st_be     = be;
        io.cp0_lsu_sync_req = sync;
        #1 chk($sformatf("st_grnt_%0h", a), io.nwa_dc_st_grnt, 1);
        @(negedge amr_clk);
        io.dc_nwa_st_req    = 1'b0;
        io.cp0_lsu_sync_req = 1'b0;
    endtask

    task automatic sync_pulse();
        io.cp0_lsu_sync_req = 1'b1;
        @(negedge amr_clk);
        io.cp0_lsu_sync_req = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (io.nwa_biu_req !== 1'b1 && n < 100) begin
            @(negedge amr_clk);
            n++;
        end
        chk({tag, "_req"}, io.nwa_biu_req, 1);
    endtask

    task automatic beat(input string tag, input logic [PADDR-1:0] a, input logic [63:0] d,
                        input logic [63:0] dm, input logic [7:0] be, input logic burst,
                        input logic last);
        wait_req(tag);
        chk({tag, "_addr"},  io.nwa_biu_addr, a);
        chk({tag, "_data"},  io.nwa_biu_data & dm, d);
        chk({tag, "_be"},    io.nwa_biu_be, be);
        chk({tag, "_burst"}, io.nwa_biu_burst, burst);
        chk({tag, "_last"},  io.nwa_biu_last, last);
        io.biu_nwa_grnt = 1'b1;
        @(negedge amr_clk);
        io.biu_nwa_grnt = 1'b0;
    endtask

    task automatic resp(input string tag);
        chk({tag, "_noreq0"}, io.nwa_biu_req, 0);
        @(negedge amr_clk);
        chk({tag, "_noreq1"}, io.nwa_biu_req, 0);
        io.biu_nwa_resp = 1'b1;
        @(negedge amr_clk);
        io.biu_nwa_resp = 1'b0;
    endtask

    function automatic logic [63:0] pat_a(input int i);
        return 64'h1111_1111_1111_1111 * 64'(i + 1);
    endfunction

    function automatic logic [63:0] pat_b(input int i);
        return 64'hF0E1_D2C3_0000_0000 | 64'(i * 3 + 1);
    endfunction

    initial begin
        io.amr_dc_wa_dis    = 1'b1;
        io.dc_nwa_st_req    = 1'b0;
        io.dc_nwa_st_addr   = '0;
        io.dc_nwa_st_data   = '0;
        io.dc_nwa_st_be     = '0;
        io.cp0_lsu_sync_req = 1'b0;
        io.biu_nwa_grnt     = 1'b0;
        io.biu_nwa_resp     = 1'b0;

        repeat (2) @(negedge amr_clk);
        chk("rst_req",   io.nwa_biu_req, 0);
        chk("rst_burst", io.nwa_biu_burst, 0);
        chk("rst_last",  io.nwa_biu_last, 0);
        chk("rst_grnt",  io.nwa_dc_st_grnt, 0);
        chk("rst_empty", io.nwa_empty, 1);
        chk("rst_addr",  io.nwa_biu_addr, 0);
        chk("rst_data",  io.nwa_biu_data, 0);
        chk("rst_be",    io.nwa_biu_be, 0);
        cpurst_b = 1'b1;
        @(negedge amr_clk);

        // Full line: burst of 8 in dword order
        for (int i = 0; i < 8; i++) store(40'h80_0000_0040 + 40'(i * 8), pat_a(i), 8'hFF, 1'b0);
        chk("full_empty_busy", io.nwa_empty, 0);
        for (int i = 0; i < 8; i++)
            beat($sformatf("full_b%0d", i), 40'h80_0000_0040 + 40'(i * 8), pat_a(i),
                 {64{1'b1}}, 8'hFF, 1'b1, i == 7);
        resp("full");
        chk("full_empty_done", io.nwa_empty, 1);

        // Partial line: two single-beat writes, each closed by a response
        store(40'h1008, 64'h0000_0000_A1A2_A3A4, 8'h0F, 1'b0);
        store(40'h1030, 64'hB1B2_B3B4_0000_0000, 8'hF0, 1'b0);
        sync_pulse();
        beat("part_b0", 40'h1008, 64'h0000_0000_A1A2_A3A4, 64'h0000_0000_FFFF_FFFF, 8'h0F, 1'b0, 1'b1);
        io.dc_nwa_st_req  = 1'b1;
        io.dc_nwa_st_addr = 40'h1010;
        io.dc_nwa_st_be   = 8'hFF;
        #1 chk("part_grnt_in_wait", io.nwa_dc_st_grnt, 0);
        io.dc_nwa_st_req  = 1'b0;
        resp("part_r0");
        beat("part_b1", 40'h1030, 64'hB1B2_B3B4_0000_0000, 64'hFFFF_FFFF_0000_0000, 8'hF0, 1'b0, 1'b1);
        resp("part_r1");
        chk("part_empty", io.nwa_empty, 1);

        // Younger store overwrites byte 1 and arrives together with sync
        store(40'h2000, 64'h0000_0000_0000_1111, 8'hFF, 1'b0);
        store(40'h2000, 64'h0000_0000_0000_AB00, 8'h02, 1'b1);
        beat("merge", 40'h2000, 64'h0000_0000_0000_AB11, {64{1'b1}}, 8'hFF, 1'b0, 1'b1);
        resp("merge");
        chk("merge_empty", io.nwa_empty, 1);

        // Different tag: refused, forces drain, then accepted from IDLE
        store(40'h3000, 64'h3333_0000_0000_3333, 8'hFF, 1'b0);
        io.dc_nwa_st_req  = 1'b1;
        io.dc_nwa_st_addr = 40'h3040;
        io.dc_nwa_st_data = 64'h4444_0000_0000_4444;
        io.dc_nwa_st_be   = 8'hFF;
        #1 chk("miss_grnt0", io.nwa_dc_st_grnt, 0);
        beat("miss_old", 40'h3000, 64'h3333_0000_0000_3333, {64{1'b1}}, 8'hFF, 1'b0, 1'b1);
        chk("miss_grnt_wait", io.nwa_dc_st_grnt, 0);
        resp("miss_old");
        #1 chk("miss_grnt1", io.nwa_dc_st_grnt, 1);
        @(negedge amr_clk);
        io.dc_nwa_st_req = 1'b0;
        chk("miss_empty_busy", io.nwa_empty, 0);
        sync_pulse();
        beat("miss_new", 40'h3040, 64'h4444_0000_0000_4444, {64{1'b1}}, 8'hFF, 1'b0, 1'b1);
        resp("miss_new");
        chk("miss_empty", io.nwa_empty, 1);

        // Backpressure on burst beat 3
        for (int i = 0; i < 8; i++) store(40'h4000 + 40'(i * 8), pat_b(i), 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++)
            beat($sformatf("bp_b%0d", i), 40'h4000 + 40'(i * 8), pat_b(i), {64{1'b1}}, 8'hFF, 1'b1, 1'b0);
        wait_req("bp_hold");
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp_hold%0d_req", c),  io.nwa_biu_req, 1);
            chk($sformatf("bp_hold%0d_addr", c), io.nwa_biu_addr, 40'h4018);
            chk($sformatf("bp_hold%0d_data", c), io.nwa_biu_data, pat_b(3));
            @(negedge amr_clk);
        end
        for (int i = 3; i < 8; i++)
            beat($sformatf("bp_b%0d", i), 40'h4000 + 40'(i * 8), pat_b(i), {64{1'b1}}, 8'hFF, 1'b1, i == 7);
        resp("bp");
        chk("bp_empty", io.nwa_empty, 1);

        // wa_dis falling drains; no acceptance while it is low
        store(40'h5000, 64'h0000_0000_0000_0055, 8'h01, 1'b0);
        io.amr_dc_wa_dis = 1'b0;
        beat("wadis", 40'h5000, 64'h0000_0000_0000_0055, 64'h0000_0000_0000_00FF, 8'h01, 1'b0, 1'b1);
        resp("wadis");
        io.dc_nwa_st_req  = 1'b1;
        io.dc_nwa_st_addr = 40'h6000;
        #1 chk("wadis_no_grnt", io.nwa_dc_st_grnt, 0);
        @(negedge amr_clk);
        io.dc_nwa_st_req = 1'b0;
        chk("wadis_empty", io.nwa_empty, 1);
        io.amr_dc_wa_dis = 1'b1;

        // Sync with nothing buffered
        sync_pulse();
        chk("idle_sync_req",   io.nwa_biu_req, 0);
        chk("idle_sync_empty", io.nwa_empty, 1);

        // No idle drain without the timeout feature
        store(40'h6000, 64'h6666_6666_6666_6666, 8'hFF, 1'b0);
        repeat (40) @(negedge amr_clk);
        chk("notmo_req",   io.nwa_biu_req, 0);
        chk("notmo_empty", io.nwa_empty, 0);
        sync_pulse();
        beat("notmo", 40'h6000, 64'h6666_6666_6666_6666, {64{1'b1}}, 8'hFF, 1'b0, 1'b1);
        resp("notmo");
        chk("notmo_empty_done", io.nwa_empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
